ex_stage_mc: RTL and testbench
==============================

Name: ex_stage_mc

Overview:
Parametrised execute stage with EX/MEM pipeline register, operand forwarding, stall/flush control and an iterative multi-cycle multiplier. Sits between the ID/EX register and the memory stage. Single-cycle ALU ops complete in one cycle. MULT takes DATA_W cycles and stalls upstream while it runs.

Parameters:
DATA_W, 32, datapath width (>=8)
REG_AW, 5, register-address width
BR_SHIFT, 2, left shift applied to the immediate for the branch target

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
id_valid  in  1  ID/EX holds a valid instruction
flush  in  1  squash current EX instruction
hold  in  1  downstream stall: freeze EX/MEM and FSM
wb_ctl  in  2  writeback control
m_ctl  in  3  [2]=branch, [1]=memread, [0]=memwrite
regdst  in  1  1: dest=instrout_1511, 0: instrout_2016
alusrc  in  1  1: B=s_extendout, 0: forwarded rdata2
aluop  in  2  ALU op class
npcout  in  DATA_W  PC+4
rdata1, rdata2  in  DATA_W  register operands
s_extendout  in  DATA_W  sign-extended immediate; [5:0]=funct
instrout_2016, instrout_1511  in  REG_AW  rt, rd
fwd_a, fwd_b  in  2  0: regfile, 1: fwd_exmem, 2: fwd_memwb, 3: regfile
fwd_exmem, fwd_memwb  in  DATA_W  forwarded values
ex_stall  out  1  upstream must hold ID/EX
ex_mem_valid  out  1  EX/MEM holds a valid instruction
wb_ctlout  out  2; branch, memread, memwrite  out  1 each
EX_MEM_NPC  out  DATA_W  branch target
zero  out  1  alu_result==0
alu_result  out  DATA_W
rdata2out  out  DATA_W  forwarded B before the alusrc mux
five_bit_muxout  out  REG_AW  destination register

Behaviour:
- Reset (async): all EX/MEM outputs 0, FSM=IDLE, counter 0. ex_stall follows its equation, which is 0 with id_valid=0 and hold=0.
- Forward muxes select A and B. The B path passes through the alusrc mux.
- Op decode:
  - aluop 00 → ADD.
  - aluop 01 → SUB.
  - aluop 10 uses funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT (signed, result 0/1), 011000 MULT.
  - aluop 11 or any other funct → ADD.
- All arithmetic is mod 2^DATA_W. MULT result is the low DATA_W bits of the unsigned product.
- Branch target = npcout + (s_extendout << BR_SHIFT), truncated.
- Non-MULT op, FSM IDLE, hold=0, flush=0: EX/MEM loads on the next edge (1-cycle latency). ex_mem_valid=id_valid. If id_valid=0, the bubble has wb/m controls = 0.
- FSM IDLE:
  - id_valid & MULT & !flush & !hold at the edge: capture A, B, ctl, dest and target. Go to BUSY with cnt=0.
  - EX/MEM loads a bubble on that edge.
- FSM BUSY:
  - Each edge with hold=0 performs one shift-add step and increments cnt.
  - On the edge at cnt=DATA_W-1, EX/MEM loads the product and captured controls with valid=1, and the FSM returns to IDLE.
  - Other BUSY edges load a bubble.
- ex_stall = hold | (IDLE & id_valid & MULT & !flush) | (BUSY & cnt!=DATA_W-1). The last BUSY cycle drops the stall so upstream advances on the same edge that retires MULT. For 32 bits, ex_stall is high for 32 cycles.
- hold=1: EX/MEM, FSM and counter are frozen, and ex_stall=1.
- flush=1: has priority over hold. At the edge, EX/MEM loads a bubble and the FSM goes to IDLE with cnt=0, aborting any multiply.
- Back-to-back MULT: the second is detected in IDLE the cycle after the first retires.
- zero is registered from the value written to alu_result.

Test Plan:
1. aluop=10, funct=100010, rdata1=7, rdata2=7, alusrc=0 → next cycle alu_result=0, zero=1, ex_mem_valid=1.
2. funct=101010, A=0xFFFFFFFF, B=1 → alu_result=1 (signed SLT); npcout=0x100, s_extendout=0xFFFFFFFF → EX_MEM_NPC=0xFC.
3. fwd_a=1 with fwd_exmem=5, fwd_b=2 with fwd_memwb=3, ADD → alu_result=8 and rdata2out=3.
4. MULT, A=0x0001_0003, B=0x0000_0005 → ex_stall high for 32 cycles, 32 bubbles, then alu_result=0x0005_000F with valid=1. MULT 0xFFFFFFFF×2 → 0xFFFFFFFE.
5. hold=1 for 3 cycles mid-MULT → completion delayed by exactly 3 cycles, same result. Flush mid-MULT → bubble, FSM IDLE, ex_stall low the next cycle.
6. Assert rst mid-MULT asynchronously → outputs 0 immediately. After release, a new ADD completes in 1 cycle.

Source files
------------

// File: rtl/ex_stage_mc.sv
// Execute stage with EX/MEM pipeline register.
// Provides operand forwarding, a single-cycle ALU and an iterative shift-add
// multiplier that stalls upstream while it runs. Flush squashes the EX
// instruction and aborts a running multiply. Hold freezes the whole stage.
module ex_stage_mc #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int BR_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic              flush,
    input  logic              hold,
    input  logic [1:0]        wb_ctl,
    input  logic [2:0]        m_ctl,
    input  logic              regdst,
    input  logic              alusrc,
    input  logic [1:0]        aluop,
    input  logic [DATA_W-1:0] npcout,
    input  logic [DATA_W-1:0] rdata1,
    input  logic [DATA_W-1:0] rdata2,
    input  logic [DATA_W-1:0] s_extendout,
    input  logic [REG_AW-1:0] instrout_2016,
    input  logic [REG_AW-1:0] instrout_1511,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic [DATA_W-1:0] fwd_exmem,
    input  logic [DATA_W-1:0] fwd_memwb,
    output logic              ex_stall,
    output logic              ex_mem_valid,
    output logic [1:0]        wb_ctlout,
    output logic              branch,
    output logic              memread,
    output logic              memwrite,
    output logic [DATA_W-1:0] EX_MEM_NPC,
    output logic              zero,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] rdata2out,
    output logic [REG_AW-1:0] five_bit_muxout
);

    // Step counter runs 0..DATA_W-1; the last value is the retiring step.
    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_MULT = 6'b011000;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_SLT,
        OP_MULT
    } alu_op_e;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;

    // Contents of the EX/MEM pipeline register.
    typedef struct packed {
        logic              valid;
        logic [1:0]        wb;
        logic [2:0]        m;
        logic [DATA_W-1:0] npc;
        logic [DATA_W-1:0] alu;
        logic              zero;
        logic [DATA_W-1:0] store;
        logic [REG_AW-1:0] dest;
    } exmem_t;

    // Instruction context held while a multiply iterates.
    typedef struct packed {
        logic [1:0]        wb;
        logic [2:0]        m;
        logic [DATA_W-1:0] npc;
        logic [DATA_W-1:0] store;
        logic [REG_AW-1:0] dest;
    } mul_ctx_t;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b_fwd;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_val;
    logic [DATA_W-1:0] br_target;
    logic [DATA_W-1:0] prod_step;
    logic [REG_AW-1:0] dest;
    logic [5:0]        funct;
    logic              is_mult;
    alu_op_e           op;

    state_e            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [DATA_W-1:0] mcand_q,  mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] prod_q,   prod_d;
    mul_ctx_t          ctx_q,    ctx_d;
    exmem_t            exmem_q,  exmem_d;

    exmem_t            issue_rec;
    exmem_t            retire_rec;
    mul_ctx_t          issue_ctx;

    assign funct     = s_extendout[5:0];
    assign op_b      = alusrc ? s_extendout : op_b_fwd;
    assign dest      = regdst ? instrout_1511 : instrout_2016;
    assign br_target = npcout + (s_extendout << BR_SHIFT);
    assign is_mult   = (op == OP_MULT);

    // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

    // Forwarding muxes for both operands; codes 0 and 3 both pick the register file.
    always_comb begin
        op_a     = rdata1;
        op_b_fwd = rdata2;
        case (fwd_a)
            2'd1:    op_a = fwd_exmem;
            2'd2:    op_a = fwd_memwb;
            default: op_a = rdata1;
        endcase
        case (fwd_b)
            2'd1:    op_b_fwd = fwd_exmem;
            2'd2:    op_b_fwd = fwd_memwb;
            default: op_b_fwd = rdata2;
        endcase
    end

    // Decode aluop/funct into an ALU operation; anything unrecognised adds.
    always_comb begin
        op = OP_ADD;
        case (aluop)
            2'b01: op = OP_SUB;
            2'b10: begin
                case (funct)
                    FN_ADD:  op = OP_ADD;
                    FN_SUB:  op = OP_SUB;
                    FN_AND:  op = OP_AND;
                    FN_OR:   op = OP_OR;
                    FN_SLT:  op = OP_SLT;
                    FN_MULT: op = OP_MULT;
                    default: op = OP_ADD;
                endcase
            end
            default: op = OP_ADD;
        endcase
    end

    // Single-cycle ALU; MULT never retires through this path, so it yields zero here.
    always_comb begin
        alu_val = op_a + op_b;
        case (op)
            OP_SUB:  alu_val = op_a - op_b;
            OP_AND:  alu_val = op_a & op_b;
            OP_OR:   alu_val = op_a | op_b;
            OP_SLT:  alu_val = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_MULT: alu_val = '0;
            default: alu_val = op_a + op_b;
        endcase
    end

    // Records for a single-cycle issue, a multiply capture and a multiply retirement.
    always_comb begin
        issue_rec       = '0;
        issue_rec.valid = id_valid;
        issue_rec.wb    = id_valid ? wb_ctl : 2'b00;
        issue_rec.m     = id_valid ? m_ctl : 3'b000;
        issue_rec.npc   = br_target;
        issue_rec.alu   = alu_val;
        issue_rec.zero  = (alu_val == '0);
        issue_rec.store = op_b_fwd;
        issue_rec.dest  = dest;

        issue_ctx       = '0;
        issue_ctx.wb    = wb_ctl;
        issue_ctx.m     = m_ctl;
        issue_ctx.npc   = br_target;
        issue_ctx.store = op_b_fwd;
        issue_ctx.dest  = dest;

        retire_rec       = '0;
        retire_rec.valid = 1'b1;
        retire_rec.wb    = ctx_q.wb;
        retire_rec.m     = ctx_q.m;
        retire_rec.npc   = ctx_q.npc;
        retire_rec.alu   = prod_step;
        retire_rec.zero  = (prod_step == '0);
        retire_rec.store = ctx_q.store;
        retire_rec.dest  = ctx_q.dest;
    end

    // Next state for the multiplier FSM, its datapath and the EX/MEM register.
    always_comb begin
        // NOTE: every variable takes its current value before any branch, so no path leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        ctx_d    = ctx_q;
        exmem_d  = exmem_q;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            exmem_d = '0;
        end else if (!hold) begin
            case (state_q)
                ST_IDLE: begin
                    if (id_valid && is_mult) begin
                        state_d  = ST_BUSY;
                        cnt_d    = '0;
                        mcand_d  = op_a;
                        mplier_d = op_b;
                        prod_d   = '0;
                        ctx_d    = issue_ctx;
                        exmem_d  = '0;
                    end else begin
                        exmem_d = issue_rec;
                    end
                end
                ST_BUSY: begin
                    prod_d   = prod_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        exmem_d = retire_rec;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        exmem_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State registers; reset clears EX/MEM immediately and abandons any multiply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the multiplier working registers are reset along with the rest, so nothing in the stage is ever X after reset.
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            ctx_q    <= '0;
            exmem_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register sample its _d from the same pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            ctx_q    <= ctx_d;
            exmem_q  <= exmem_d;
        end
    end

    // The final BUSY cycle drops the stall so upstream advances on the retiring edge.
    assign ex_stall = hold
                    | ((state_q == ST_IDLE) & id_valid & is_mult & ~flush)
                    | ((state_q == ST_BUSY) & (cnt_q != CNT_LAST));

    assign ex_mem_valid    = exmem_q.valid;
    assign wb_ctlout       = exmem_q.wb;
    assign branch          = exmem_q.m[2];
    assign memread         = exmem_q.m[1];
    assign memwrite        = exmem_q.m[0];
    assign EX_MEM_NPC      = exmem_q.npc;
    assign zero            = exmem_q.zero;
    assign alu_result      = exmem_q.alu;
    assign rdata2out       = exmem_q.store;
    assign five_bit_muxout = exmem_q.dest;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Self-checking bench for ex_stage_mc: vector table, hand-written multiply
// sequences (hold, flush, reset) and a randomized run against a reference model.
module tb_ex_stage_mc;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, flush, hold;
    logic [1:0]    wb_ctl;
    logic [2:0]    m_ctl;
    logic          regdst, alusrc;
    logic [1:0]    aluop;
    logic [DW-1:0] npcout, rdata1, rdata2, s_extendout;
    logic [AW-1:0] instrout_2016, instrout_1511;
    logic [1:0]    fwd_a, fwd_b;
    logic [DW-1:0] fwd_exmem, fwd_memwb;
    logic          ex_stall, ex_mem_valid;
    logic [1:0]    wb_ctlout;
    logic          branch, memread, memwrite;
    logic [DW-1:0] EX_MEM_NPC;
    logic          zero;
    logic [DW-1:0] alu_result, rdata2out;
    logic [AW-1:0] five_bit_muxout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_stage_mc #(.DATA_W(DW), .REG_AW(AW), .BR_SHIFT(2)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush), .hold(hold),
        .wb_ctl(wb_ctl), .m_ctl(m_ctl), .regdst(regdst), .alusrc(alusrc), .aluop(aluop),
        .npcout(npcout), .rdata1(rdata1), .rdata2(rdata2), .s_extendout(s_extendout),
        .instrout_2016(instrout_2016), .instrout_1511(instrout_1511),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_exmem(fwd_exmem), .fwd_memwb(fwd_memwb),
        .ex_stall(ex_stall), .ex_mem_valid(ex_mem_valid), .wb_ctlout(wb_ctlout),
        .branch(branch), .memread(memread), .memwrite(memwrite), .EX_MEM_NPC(EX_MEM_NPC),
        .zero(zero), .alu_result(alu_result), .rdata2out(rdata2out),
        .five_bit_muxout(five_bit_muxout)
    );

    // Expected EX/MEM contents.
    typedef struct packed {
        logic          valid;
        logic [1:0]    wb;
        logic [2:0]    m;
        logic [DW-1:0] npc;
        logic [DW-1:0] alu;
        logic [DW-1:0] r2;
        logic [AW-1:0] dest;
    } exp_t;

    typedef struct packed {
        logic [1:0]    aluop;
        logic [1:0]    fa, fb;
        logic          alusrc;
        logic [DW-1:0] r1, r2, imm, fex, fmem, npc;
        logic [DW-1:0] e_alu, e_r2, e_npc;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] fwd_sel(input logic [1:0] sel, input logic [DW-1:0] rf,
                                              input logic [DW-1:0] ex, input logic [DW-1:0] mem);
        if (sel == 2'd1) return ex;
        if (sel == 2'd2) return mem;
        return rf;
    endfunction

    function automatic logic ref_is_mult(input logic [1:0] op, input logic [5:0] f);
        return (op == 2'b10) && (f == 6'h18);
    endfunction

    function automatic logic [DW-1:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                              input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (op == 2'b01) return a - b;
        if (op == 2'b10) begin
            if (f == 6'h22) return a - b;
            if (f == 6'h24) return a & b;
            if (f == 6'h25) return a | b;
            if (f == 6'h2A) return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
            if (f == 6'h18) return a * b;
        end
        return a + b;
    endfunction

    // What EX/MEM should hold if the current inputs were issued and completed.
    function automatic exp_t ref_now();
        exp_t          e;
        logic [DW-1:0] a, bf, b;
        a       = fwd_sel(fwd_a, rdata1, fwd_exmem, fwd_memwb);
        bf      = fwd_sel(fwd_b, rdata2, fwd_exmem, fwd_memwb);
        b       = alusrc ? s_extendout : bf;
        e.valid = id_valid;
        e.wb    = id_valid ? wb_ctl : 2'b00;
        e.m     = id_valid ? m_ctl : 3'b000;
        e.npc   = npcout + s_extendout * 4;
        e.alu   = ref_alu(aluop, s_extendout[5:0], a, b);
        e.r2    = bf;
        e.dest  = regdst ? instrout_1511 : instrout_2016;
        return e;
    endfunction

    task automatic chk_exmem(input string tag, input exp_t e);
        check({tag, " valid"}, 64'(ex_mem_valid), 64'(e.valid));
        check({tag, " ctl"}, 64'({wb_ctlout, branch, memread, memwrite}), 64'({e.wb, e.m}));
        if (e.valid) begin
            check({tag, " npc"}, 64'(EX_MEM_NPC), 64'(e.npc));
            check({tag, " alu"}, 64'(alu_result), 64'(e.alu));
            check({tag, " zero"}, 64'(zero), 64'(e.alu == '0));
            check({tag, " r2out"}, 64'(rdata2out), 64'(e.r2));
            check({tag, " dest"}, 64'(five_bit_muxout), 64'(e.dest));
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [1:0] fa, input logic [1:0] fb,
                                input logic src, input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                                input logic [DW-1:0] imm, input logic [DW-1:0] fex,
                                input logic [DW-1:0] fmem, input logic [DW-1:0] npc,
                                input logic [DW-1:0] e_alu, input logic [DW-1:0] e_r2,
                                input logic [DW-1:0] e_npc);
        vec_t v;
        v.aluop = op;  v.fa = fa;  v.fb = fb;  v.alusrc = src;
        v.r1 = r1;  v.r2 = r2;  v.imm = imm;  v.fex = fex;  v.fmem = fmem;  v.npc = npc;
        v.e_alu = e_alu;  v.e_r2 = e_r2;  v.e_npc = e_npc;
        return v;
    endfunction

    task automatic set_idle();
        id_valid = 1'b0; flush = 1'b0; hold = 1'b0; wb_ctl = '0; m_ctl = '0;
        regdst = 1'b0; alusrc = 1'b0; aluop = '0; npcout = '0; rdata1 = '0; rdata2 = '0;
        s_extendout = '0; instrout_2016 = '0; instrout_1511 = '0; fwd_a = '0; fwd_b = '0;
        fwd_exmem = '0; fwd_memwb = '0;
    endtask

    task automatic set_mult(input logic [DW-1:0] a, input logic [DW-1:0] b);
        set_idle();
        id_valid = 1'b1; aluop = 2'b10; s_extendout = 32'h18; rdata1 = a; rdata2 = b;
        wb_ctl = 2'b11; regdst = 1'b1; instrout_1511 = 5'd9; npcout = 32'h200;
    endtask

    // Runs one MULT to completion, optionally holding for hold_len cycles from iteration hold_at.
    task automatic do_mult(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input int hold_at, input int hold_len);
        int            iter;
        int            stalls;
        int            bubbles;
        logic          done;
        logic [DW-1:0] prod;
        iter = 0; stalls = 0; bubbles = 0; done = 1'b0;
        prod = a * b;
        set_mult(a, b);
        while (!done && iter < 120) begin
            hold = (hold_at >= 0) && (iter >= hold_at) && (iter < hold_at + hold_len);
            #1;
            if (ex_stall) stalls++;
            @(posedge clk); #1;
            iter++;
            if (ex_mem_valid) done = 1'b1;
            else bubbles++;
        end
        hold = 1'b0;
        check({tag, " completed"}, 64'(done), 64'd1);
        check({tag, " latency"}, 64'(iter), 64'(33 + hold_len));
        check({tag, " stall cycles"}, 64'(stalls), 64'(32 + hold_len));
        check({tag, " bubbles"}, 64'(bubbles), 64'(32 + hold_len));
        check({tag, " product"}, 64'(alu_result), 64'(prod));
        check({tag, " zero"}, 64'(zero), 64'(prod == '0));
        check({tag, " wb"}, 64'(wb_ctlout), 64'd3);
        check({tag, " dest"}, 64'(five_bit_muxout), 64'd9);
        check({tag, " npc"}, 64'(EX_MEM_NPC), 64'(32'h200 + 32'h60));
    endtask

    task automatic rand_inputs();
        int            r;
        logic [5:0]    f;
        logic [DW-1:0] t;
        id_valid = ($urandom_range(0, 9) < 8);
        hold     = ($urandom_range(0, 11) == 0);
        flush    = ($urandom_range(0, 19) == 0);
        aluop    = 2'($urandom_range(0, 3));
        r = int'($urandom_range(0, 11));
        case (r)
            0:       f = 6'h18;
            1, 2:    f = 6'h20;
            3, 4:    f = 6'h22;
            5:       f = 6'h24;
            6:       f = 6'h25;
            7, 8:    f = 6'h2A;
            default: f = 6'($urandom());
        endcase
        t = DW'($urandom());
        s_extendout   = {t[DW-1:6], f};
        rdata1        = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom());
        rdata2        = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 15)) : DW'($urandom());
        fwd_exmem     = DW'($urandom());
        fwd_memwb     = DW'($urandom());
        fwd_a         = 2'($urandom_range(0, 3));
        fwd_b         = 2'($urandom_range(0, 3));
        alusrc        = 1'($urandom_range(0, 1));
        regdst        = 1'($urandom_range(0, 1));
        wb_ctl        = 2'($urandom_range(0, 3));
        m_ctl         = 3'($urandom_range(0, 7));
        npcout        = DW'($urandom());
        instrout_2016 = AW'($urandom());
        instrout_1511 = AW'($urandom());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[15];
        exp_t          m_exp;
        exp_t          m_pend;
        logic          m_busy;
        int            m_left;
        logic          e_stall;
        logic          mult_now;
        int            valids;

        vecs[0]  = mk(2'b10, 0, 0, 0, 7, 7, 32'h22, 0, 0, 0, 0, 7, 32'h88);
        vecs[1]  = mk(2'b10, 0, 0, 0, 32'hFFFF_FFFF, 1, 32'h2A, 0, 0, 32'h100, 1, 1, 32'h1A8);
        vecs[2]  = mk(2'b00, 0, 0, 0, 32'h10, 32'h20, 32'hFFFF_FFFF, 0, 0, 32'h100, 32'h30, 32'h20, 32'hFC);
        vecs[3]  = mk(2'b00, 1, 2, 0, 100, 200, 0, 5, 3, 32'h40, 8, 3, 32'h40);
        vecs[4]  = mk(2'b10, 0, 0, 0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h24, 0, 0, 0, 32'h00F0_1200, 32'h0FF0_FF00, 32'h90);
        vecs[5]  = mk(2'b10, 0, 0, 0, 32'hF000_0000, 32'hF, 32'h25, 0, 0, 0, 32'hF000_000F, 32'hF, 32'h94);
        vecs[6]  = mk(2'b01, 0, 0, 0, 3, 5, 0, 0, 0, 32'h8, 32'hFFFF_FFFE, 5, 32'h8);
        vecs[7]  = mk(2'b11, 0, 0, 0, 3, 5, 32'h22, 0, 0, 0, 8, 5, 32'h88);
        vecs[8]  = mk(2'b10, 0, 0, 0, 1, 2, 32'h3F, 0, 0, 0, 3, 2, 32'hFC);
        vecs[9]  = mk(2'b00, 0, 0, 1, 32'h100, 32'h55, 32'h10, 0, 0, 0, 32'h110, 32'h55, 32'h40);
        vecs[10] = mk(2'b10, 0, 0, 0, 5, 32'hFFFF_FFFF, 32'h2A, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hA8);
        vecs[11] = mk(2'b00, 3, 1, 0, 9, 32'h77, 0, 32'h11, 32'h99, 0, 32'h1A, 32'h11, 0);
        vecs[12] = mk(2'b00, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 32'h4, 0, 1, 32'h4);
        vecs[13] = mk(2'b01, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 1, 0);
        vecs[14] = mk(2'b10, 0, 0, 0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2A, 0, 0, 0, 1, 32'h7FFF_FFFF, 32'hA8);

        // Reset state.
        rst = 1'b1;
        set_idle();
        #1;
        check("reset valid", 64'(ex_mem_valid), 64'd0);
        check("reset ctl", 64'({wb_ctlout, branch, memread, memwrite}), 64'd0);
        check("reset alu", 64'(alu_result), 64'd0);
        check("reset npc", 64'(EX_MEM_NPC), 64'd0);
        check("reset r2out/dest/zero", 64'({rdata2out, five_bit_muxout, zero}), 64'd0);
        check("reset stall", 64'(ex_stall), 64'd0);
        #20;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single-cycle vector table.
        for (int i = 0; i < 15; i++) begin
            exp_t e;
            set_idle();
            id_valid = 1'b1; aluop = vecs[i].aluop; fwd_a = vecs[i].fa; fwd_b = vecs[i].fb;
            alusrc = vecs[i].alusrc; rdata1 = vecs[i].r1; rdata2 = vecs[i].r2;
            s_extendout = vecs[i].imm; fwd_exmem = vecs[i].fex; fwd_memwb = vecs[i].fmem;
            npcout = vecs[i].npc; regdst = i[0]; instrout_2016 = AW'(i); instrout_1511 = AW'(31 - i);
            wb_ctl = 2'(i); m_ctl = 3'(i + 1);
            e.valid = 1'b1; e.wb = 2'(i); e.m = 3'(i + 1); e.npc = vecs[i].e_npc;
            e.alu = vecs[i].e_alu; e.r2 = vecs[i].e_r2; e.dest = i[0] ? AW'(31 - i) : AW'(i);
            #1;
            check($sformatf("vec%0d stall", i), 64'(ex_stall), 64'd0);
            @(posedge clk); #1;
            chk_exmem($sformatf("vec%0d", i), e);
        end

        // A non-valid ID/EX produces a bubble with cleared controls.
        set_idle();
        wb_ctl = 2'b11; m_ctl = 3'b111;
        @(posedge clk); #1;
        check("bubble valid", 64'(ex_mem_valid), 64'd0);
        check("bubble ctl", 64'({wb_ctlout, branch, memread, memwrite}), 64'd0);

        // Multiply: basic, back-to-back, and with a 3-cycle hold.
        do_mult("mult1", 32'h0001_0003, 32'h0000_0005, -1, 0);
        check("mult1 value", 64'(alu_result), 64'h0005_000F);
        do_mult("mult2", 32'hFFFF_FFFF, 32'h2, -1, 0);
        check("mult2 value", 64'(alu_result), 64'hFFFF_FFFE);
        do_mult("mult_hold", 32'h0001_0003, 32'h0000_0005, 10, 3);

        // Flush (together with hold, which it overrides) aborts a running multiply.
        set_mult(32'h1234, 32'h5678);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1; hold = 1'b1;
        #1;
        check("flush stall during busy", 64'(ex_stall), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0; hold = 1'b0; id_valid = 1'b0;
        #1;
        check("flush valid", 64'(ex_mem_valid), 64'd0);
        check("flush stall next", 64'(ex_stall), 64'd0);
        valids = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ex_mem_valid) valids++;
        end
        check("flush no late retire", 64'(valids), 64'd0);

        // Asynchronous reset mid-multiply, then a single-cycle ADD.
        set_mult(32'h7, 32'h9);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        id_valid = 1'b0;
        #1;
        check("rst mid-mult valid", 64'(ex_mem_valid), 64'd0);
        check("rst mid-mult stall", 64'(ex_stall), 64'd0);
        rst = 1'b0;
        set_idle();
        id_valid = 1'b1; rdata1 = 32'd40; rdata2 = 32'd2; wb_ctl = 2'b01; m_ctl = 3'b010;
        @(posedge clk); #1;
        check("post-rst add valid", 64'(ex_mem_valid), 64'd1);
        check("post-rst add alu", 64'(alu_result), 64'd42);
        check("post-rst add ctl", 64'({wb_ctlout, branch, memread, memwrite}), 64'b01010);
        #1;
        rst = 1'b1;
        #1;
        check("async rst alu", 64'(alu_result), 64'd0);
        check("async rst valid/ctl", 64'({ex_mem_valid, wb_ctlout, branch, memread, memwrite}), 64'd0);
        rst = 1'b0;

        // Randomized run against the reference model, starting from a fresh idle stage.
        @(posedge clk); #1;
        m_busy = 1'b0; m_left = 0; m_exp = '0; m_pend = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rand_inputs();
            #1;
            mult_now = ref_is_mult(aluop, s_extendout[5:0]);
            e_stall  = hold | (!m_busy && id_valid && mult_now && !flush) | (m_busy && m_left != 1);
            check($sformatf("rnd%0d stall", cyc), 64'(ex_stall), 64'(e_stall));
            if (flush) begin
                m_exp  = '0;
                m_busy = 1'b0;
            end else if (!hold) begin
                if (!m_busy) begin
                    if (id_valid && mult_now) begin
                        m_pend = ref_now();
                        m_busy = 1'b1;
                        m_left = DW;
                        m_exp  = '0;
                    end else begin
                        m_exp = ref_now();
                    end
                end else if (m_left == 1) begin
                    m_exp  = m_pend;
                    m_busy = 1'b0;
                end else begin
                    m_left--;
                    m_exp = '0;
                end
            end
            @(posedge clk); #1;
            chk_exmem($sformatf("rnd%0d", cyc), m_exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
